bp_fe_bht_ctrl: RTL and testbench
=================================

BP_FE_BHT_CTRL -- requirements
Module: bp_fe_bht_ctrl

Interface
REQ-001 SHALL have parameter bht_idx_width_p, default 9, BHT index width; table depth els = 2**bht_idx_width_p.
REQ-002 SHALL have parameter starve_limit_p, default 4, max consecutive cycles a pending update may lose to reads.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 reset_n_i  input  1  asynchronous, active-low reset.
REQ-005 clear_i  input  1  synchronous request to re-initialise the table.
REQ-006 r_v_i  input  1  fetch-side prediction read request.
REQ-007 r_idx_i  input  bht_idx_width_p  read index.
REQ-008 r_ready_o  output  1  read accepted this cycle when r_v_i & r_ready_o.
REQ-009 w_v_i  input  1  backend update request.
REQ-010 w_idx_i  input  bht_idx_width_p  update index.
REQ-011 w_val_i  input  2  counter value returned with the prediction.
REQ-012 w_taken_i  input  1  resolved branch direction.
REQ-013 w_ready_o  output  1  update accepted when w_v_i & w_ready_o.
REQ-014 mem_v_o, mem_w_o  output  1 each  single-port table access valid / write-not-read.
REQ-015 mem_idx_o  output  bht_idx_width_p  table index.
REQ-016 mem_data_o  output  2  write data.
REQ-017 init_done_o  output  1  high in RUN state.

Function
REQ-018 SHALL implement FSM states INIT and RUN.
REQ-019 INIT: each cycle drive mem_v_o=1, mem_w_o=1, mem_idx_o=init_cnt, mem_data_o=2'b01, and increment init_cnt.
REQ-020 INIT -> RUN on the cycle after the write with init_cnt=els-1; INIT lasts exactly els cycles.
REQ-021 In INIT, r_ready_o=0, w_ready_o=0, init_done_o=0, and r_v_i/w_v_i are ignored.
REQ-022 clear_i sampled high in any state: next state INIT, init_cnt=0, update queue emptied, starve_cnt=0; an access driven in that cycle still completes.
REQ-023 Updates are buffered in a 2-entry FIFO of {idx, new_val}.
REQ-024 new_val = taken ? min(w_val_i+1, 3) : max(w_val_i-1, 0); 2-bit saturating arithmetic, computed at enqueue.
REQ-025 In RUN, w_ready_o = ~full; a full FIFO rejects even when a dequeue occurs the same cycle.
REQ-026 No bypass: an entry enqueued in cycle t is eligible for issue no earlier than t+1.
REQ-027 Port select in RUN: issue FIFO head as write if non-empty and (r_v_i=0 or starve_cnt==starve_limit_p); otherwise issue read if r_v_i; otherwise mem_v_o=0.
REQ-028 r_ready_o = init_done_o & ~(FIFO non-empty & starve_cnt==starve_limit_p).
REQ-029 Read issue: mem_v_o=1, mem_w_o=0, mem_idx_o=r_idx_i, combinational in the same cycle; mem_data_o=0.
REQ-030 Write issue: mem_v_o=1, mem_w_o=1, head idx/new_val driven; head popped at end of cycle.
REQ-031 starve_cnt increments (saturating at starve_limit_p) each cycle FIFO non-empty and a read issues; cleared on write issue or FIFO empty.
REQ-032 Simultaneous enqueue and dequeue on a non-full FIFO SHALL leave occupancy unchanged and preserve order.
REQ-033 FIFO pointers SHALL wrap modulo 2; no entry lost or duplicated.

Reset
REQ-034 reset_n_i low asynchronously forces INIT, init_cnt=0, FIFO empty, starve_cnt=0.
REQ-035 During reset, all outputs SHALL be 0 except mem_v_o=1, mem_w_o=1, mem_idx_o=0, mem_data_o=2'b01 (INIT cycle 0 values).
REQ-036 Reset deassertion mid-INIT or mid-RUN SHALL restart INIT from index 0.

Verification
REQ-037 Release reset with bht_idx_width_p=3 -> 8 writes idx 0..7 data 01, init_done_o=1 on cycle 9.
REQ-038 RUN, w_v_i idx=5 val=3 taken=1, no reads -> next cycle write idx 5 data 3; val=0 taken=0 -> data 0; val=1 taken=1 -> data 2.
REQ-039 RUN, r_v_i held high, one queued update, starve_limit_p=4 -> 4 reads issue, 5th cycle r_ready_o=0 and write issues.
REQ-040 Two updates queued, w_v_i third -> w_ready_o=0, third not accepted until a pop completes the following cycle.
REQ-041 clear_i pulsed with 2 queued updates -> queue dropped, full INIT sweep repeats, no stale write afterward.
REQ-042 reset_n_i asserted mid-RUN with pending update -> outputs immediately match REQ-035; no update issued after release.

Source files
------------

// File: rtl/bp_fe_bht_ctrl.sv
// ---------------------------------------------------------------------------
// bp_fe_bht_ctrl
//
// Controller for a single-port branch history table (BHT) of 2-bit
// saturating counters. It sits between the fetch-side prediction reads, the
// backend counter updates and the one table port.
//
// After reset or clear the controller sweeps the whole table and writes the
// counter value 2'b01 (weakly not-taken) to every entry. Reads and updates
// are refused until the sweep is finished. During normal operation, updates
// are placed in a 2-entry queue. The new counter value is computed when the
// update is accepted. Reads are normally given the table port. A pending
// update takes the port only when no read is requested, or when it has
// already lost to reads starve_limit_p times in a row.
//
// Parameters
//   bht_idx_width_p : table index width, table depth els = 2**bht_idx_width_p
//   starve_limit_p  : number of consecutive cycles a queued update may lose
//                     the port to reads before it is forced through
//
// Ports
//   clk_i        : clock, rising edge
//   reset_n_i    : asynchronous active-low reset
//   clear_i      : synchronous request to re-initialise the table
//   r_v_i        : prediction read request
//   r_idx_i      : prediction read index
//   r_ready_o    : read accepted when r_v_i & r_ready_o
//   w_v_i        : counter update request
//   w_idx_i      : update index
//   w_val_i      : counter value that came with the prediction
//   w_taken_i    : resolved branch direction
//   w_ready_o    : update accepted when w_v_i & w_ready_o
//   mem_v_o      : table access valid
//   mem_w_o      : table access is a write (0 = read)
//   mem_idx_o    : table index
//   mem_data_o   : table write data
//   init_done_o  : table initialised, normal operation
// ---------------------------------------------------------------------------
module bp_fe_bht_ctrl #(
  parameter int bht_idx_width_p = 9,
  parameter int starve_limit_p  = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       clear_i,

  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] r_idx_i,
  output logic                       r_ready_o,

  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] w_idx_i,
  input  logic [1:0]                 w_val_i,
  input  logic                       w_taken_i,
  output logic                       w_ready_o,

  output logic                       mem_v_o,
  output logic                       mem_w_o,
  output logic [bht_idx_width_p-1:0] mem_idx_o,
  output logic [1:0]                 mem_data_o,

  output logic                       init_done_o
);

  localparam int starve_w = (starve_limit_p < 1) ? 1 : $clog2(starve_limit_p + 1);

  localparam logic [starve_w-1:0]        starve_limit_c = starve_w'(starve_limit_p);
  localparam logic [starve_w-1:0]        starve_one_c   = starve_w'(1);
  localparam logic [bht_idx_width_p-1:0] init_last_c    = {bht_idx_width_p{1'b1}};
  localparam logic [1:0]                 init_val_c     = 2'b01;

  localparam logic [0:0] state_init = 1'b0;
  localparam logic [0:0] state_run  = 1'b1;

  // 2-bit saturating counter step in the resolved direction.
  function automatic logic [1:0] sat_update(input logic [1:0] val,
                                            input logic       taken);
    logic [1:0] res;
    if (taken) begin
      res = (val == 2'b11) ? 2'b11 : val + 2'd1;
    end else begin
      res = (val == 2'b00) ? 2'b00 : val - 2'd1;
    end
    return res;
  endfunction

  // Control state
  logic [0:0]                 state_r;
  logic [bht_idx_width_p-1:0] init_cnt_r;
  logic                       wptr_r;
  logic                       rptr_r;
  logic [1:0]                 count_r;
  logic [starve_w-1:0]        starve_cnt_r;

  // Update queue storage (data only, validity comes from count_r)
  logic [bht_idx_width_p-1:0] fifo_idx_r [2];
  logic [1:0]                 fifo_val_r [2];

  logic run;
  logic fifo_empty;
  logic fifo_full;
  logic starve_hit;
  logic wr_issue;
  logic rd_issue;
  logic enq;
  logic deq;

  assign run        = (state_r == state_run);
  assign fifo_empty = (count_r == 2'd0);
  assign fifo_full  = (count_r == 2'd2);
  assign starve_hit = (starve_cnt_r == starve_limit_c);

  // The queue head goes out when reads leave the port free, or when it has
  // already lost the port too many times in a row. Otherwise a requested
  // read wins.
  assign wr_issue = run & ~fifo_empty & (~r_v_i | starve_hit);
  assign rd_issue = run & ~wr_issue & r_v_i;

  // A full queue refuses an update even if the head leaves in the same
  // cycle. A new entry cannot be issued in the cycle it is written, because
  // the head is always taken from registered storage.
  assign enq = run & w_v_i & ~fifo_full;
  assign deq = wr_issue;

  assign init_done_o = run;
  assign r_ready_o   = run & ~(~fifo_empty & starve_hit);
  assign w_ready_o   = run & ~fifo_full;

  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_idx_o  = '0;
    mem_data_o = 2'b00;
    if (!run) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_idx_o  = init_cnt_r;
      mem_data_o = init_val_c;
    end else if (wr_issue) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_idx_o  = fifo_idx_r[rptr_r];
      mem_data_o = fifo_val_r[rptr_r];
    end else if (rd_issue) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b0;
      mem_idx_o  = r_idx_i;
      mem_data_o = 2'b00;
    end
  end

  // Init sweep / run state. Clear takes priority over all other state
  // updates. The access shown on the port in the clear cycle is still
  // driven, because the outputs depend only on the current state.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= state_init;
      init_cnt_r <= '0;
    end else if (clear_i) begin
      state_r    <= state_init;
      init_cnt_r <= '0;
    end else if (!run) begin
      init_cnt_r <= init_cnt_r + 1'b1;
      if (init_cnt_r == init_last_c) begin
        state_r <= state_run;
      end
    end
  end

  // Queue pointers and occupancy. The pointers are one bit wide, so they
  // wrap modulo 2 on their own.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else if (clear_i) begin
      wptr_r  <= 1'b0;
      rptr_r  <= 1'b0;
      count_r <= 2'd0;
    end else begin
      if (enq) begin
        wptr_r <= ~wptr_r;
      end
      if (deq) begin
        rptr_r <= ~rptr_r;
      end
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // The new counter value is computed here, so the issue path only has to
  // forward stored data.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      fifo_idx_r[wptr_r] <= w_idx_i;
      fifo_val_r[wptr_r] <= sat_update(w_val_i, w_taken_i);
    end
  end

  // Counts the consecutive cycles in which the queue head lost the port to
  // a read. The count stops at the limit. It is cleared when the head is
  // issued or when the queue is empty.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_cnt_r <= '0;
    end else if (clear_i) begin
      starve_cnt_r <= '0;
    end else if (fifo_empty || wr_issue) begin
      starve_cnt_r <= '0;
    end else if (rd_issue && !starve_hit) begin
      starve_cnt_r <= starve_cnt_r + starve_one_c;
    end
  end

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bp_fe_bht_ctrl
//
// Directed bench for bp_fe_bht_ctrl with an 8-entry table and a starvation
// limit of 4. Inputs change on the falling edge. Outputs are sampled 1 ns
// later, well before the next rising edge. Each observation packs all
// outputs into one vector, {mem_v, mem_w, mem_idx, mem_data, r_ready,
// w_ready, init_done}, and compares it with a hand-computed value. When the
// port is idle, the index, data and write flag are masked out of the
// comparison.
// ---------------------------------------------------------------------------
module tb_bp_fe_bht_ctrl;

  localparam int IW = 3;

  localparam logic [9:0] M_ALL  = 10'h3FF;
  localparam logic [9:0] M_IDLE = 10'b10_000_00_111;

  logic          clk;
  logic          reset_n;
  logic          clear;
  logic          r_v;
  logic [IW-1:0] r_idx;
  logic          r_ready;
  logic          w_v;
  logic [IW-1:0] w_idx;
  logic [1:0]    w_val;
  logic          w_taken;
  logic          w_ready;
  logic          mem_v;
  logic          mem_w;
  logic [IW-1:0] mem_idx;
  logic [1:0]    mem_data;
  logic          init_done;

  int compared;
  int mismatched;

  logic [9:0] obs;
  assign obs = {mem_v, mem_w, mem_idx, mem_data, r_ready, w_ready, init_done};

  bp_fe_bht_ctrl #(
    .bht_idx_width_p(IW),
    .starve_limit_p (4)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .clear_i    (clear),
    .r_v_i      (r_v),
    .r_idx_i    (r_idx),
    .r_ready_o  (r_ready),
    .w_v_i      (w_v),
    .w_idx_i    (w_idx),
    .w_val_i    (w_val),
    .w_taken_i  (w_taken),
    .w_ready_o  (w_ready),
    .mem_v_o    (mem_v),
    .mem_w_o    (mem_w),
    .mem_idx_o  (mem_idx),
    .mem_data_o (mem_data),
    .init_done_o(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] ex(input logic v, input logic w,
                                    input logic [IW-1:0] idx,
                                    input logic [1:0] data, input logic rr,
                                    input logic wr, input logic dn);
    return {v, w, idx, data, rr, wr, dn};
  endfunction

  task automatic test_reset();
    logic [9:0] e;
    reset_n = 1'b0; clear = 1'b0;
    r_v = 1'b1; r_idx = 3'd4; w_v = 1'b1; w_idx = 3'd2; w_val = 2'd3; w_taken = 1'b1;
    #1;
    e = ex(1, 1, 0, 2'b01, 0, 0, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL reset_outputs got=%b want=%b", obs, e);
    end
    @(negedge clk); @(negedge clk);
    #1;
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL reset_held got=%b want=%b", obs, e);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Reads and updates stay requested during the sweep and must be ignored.
  task automatic test_init();
    logic [9:0] e;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = ex(1, 1, IW'(i), 2'b01, 0, 0, 0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL init_sweep[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
    end
    r_v = 1'b0; w_v = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 1, 1, 1);
    compared++;
    if ((obs & M_IDLE) !== (e & M_IDLE)) begin
      mismatched++;
      $display("FAIL init_done got=%b want=%b", obs, e);
    end
  endtask

  task automatic test_update();
    logic [IW-1:0] t_idx [4] = '{3'd5, 3'd5, 3'd5, 3'd4};
    logic [1:0]    t_val [4] = '{2'd3, 2'd0, 2'd1, 2'd2};
    logic          t_tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]    t_exp [4] = '{2'd3, 2'd0, 2'd2, 2'd1};
    logic [9:0] e;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      w_v = 1'b1; w_idx = t_idx[i]; w_val = t_val[i]; w_taken = t_tk[i]; r_v = 1'b0;
      #1;
      e = ex(0, 0, 0, 0, 1, 1, 1);
      compared++;
      if ((obs & M_IDLE) !== (e & M_IDLE)) begin
        mismatched++;
        $display("FAIL update_nobypass[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
      w_v = 1'b0;
      #1;
      e = ex(1, 1, t_idx[i], t_exp[i], 1, 1, 1);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL update_write[%0d] got=%b want=%b", i, obs, e);
      end
    end
  endtask

  task automatic test_starve();
    logic [9:0] e;
    @(negedge clk);
    w_v = 1'b1; w_idx = 3'd2; w_val = 2'd1; w_taken = 1'b0; r_v = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 1, 1, 1);
    compared++;
    if ((obs & M_IDLE) !== (e & M_IDLE)) begin
      mismatched++;
      $display("FAIL starve_enq got=%b want=%b", obs, e);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      w_v = 1'b0; r_v = 1'b1; r_idx = IW'(k + 3);
      #1;
      e = ex(1, 0, IW'(k + 3), 0, 1, 1, 1);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL starve_read[%0d] got=%b want=%b", k, obs, e);
      end
    end
    @(negedge clk);
    r_idx = 3'd7;
    #1;
    e = ex(1, 1, 3'd2, 2'd0, 0, 1, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL starve_forced_write got=%b want=%b", obs, e);
    end
    @(negedge clk);
    r_idx = 3'd1;
    #1;
    e = ex(1, 0, 3'd1, 0, 1, 1, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL starve_after got=%b want=%b", obs, e);
    end
    @(negedge clk);
    r_v = 1'b0;
  endtask

  // Reads keep the queue from draining while it fills. The fourth and fifth
  // cycles check that a full queue refuses even with a pop, then the
  // enqueue+dequeue cycle, then the order in which entries are written.
  task automatic test_full();
    logic [IW-1:0] c_ridx [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
    logic          c_rv   [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic          c_wv   [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [IW-1:0] c_widx [7] = '{3'd1, 3'd3, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0};
    logic [1:0]    c_wval [7] = '{2'd0, 2'd3, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    logic          c_wtk  [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [9:0]    c_exp  [7];
    logic [9:0]    c_msk  [7];
    c_exp[0] = ex(1, 0, 3'd0, 0, 1, 1, 1);    c_msk[0] = M_ALL;
    c_exp[1] = ex(1, 0, 3'd1, 0, 1, 1, 1);    c_msk[1] = M_ALL;
    c_exp[2] = ex(1, 0, 3'd2, 0, 1, 0, 1);    c_msk[2] = M_ALL;
    c_exp[3] = ex(1, 1, 3'd1, 2'd1, 1, 0, 1); c_msk[3] = M_ALL;
    c_exp[4] = ex(1, 1, 3'd3, 2'd2, 1, 1, 1); c_msk[4] = M_ALL;
    c_exp[5] = ex(1, 1, 3'd6, 2'd0, 1, 1, 1); c_msk[5] = M_ALL;
    c_exp[6] = ex(0, 0, 0, 0, 1, 1, 1);       c_msk[6] = M_IDLE;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      r_v = c_rv[c]; r_idx = c_ridx[c];
      w_v = c_wv[c]; w_idx = c_widx[c]; w_val = c_wval[c]; w_taken = c_wtk[c];
      #1;
      compared++;
      if ((obs & c_msk[c]) !== (c_exp[c] & c_msk[c])) begin
        mismatched++;
        $display("FAIL full_cycle[%0d] got=%b want=%b", c, obs, c_exp[c]);
      end
    end
  endtask

  task automatic test_clear();
    logic [9:0] e;
    @(negedge clk);
    r_v = 1'b1; r_idx = 3'd3; w_v = 1'b1; w_idx = 3'd7; w_val = 2'd0; w_taken = 1'b1;
    @(negedge clk);
    w_idx = 3'd6;
    @(negedge clk);
    w_v = 1'b0; clear = 1'b1; r_idx = 3'd5;
    #1;
    e = ex(1, 0, 3'd5, 0, 1, 0, 1);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL clear_cycle_read got=%b want=%b", obs, e);
    end
    @(negedge clk);
    clear = 1'b0; r_v = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = ex(1, 1, IW'(i), 2'b01, 0, 0, 0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL clear_sweep[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      e = ex(0, 0, 0, 0, 1, 1, 1);
      compared++;
      if ((obs & M_IDLE) !== (e & M_IDLE)) begin
        mismatched++;
        $display("FAIL clear_no_stale[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] e;
    w_v = 1'b1; w_idx = 3'd4; w_val = 2'd2; w_taken = 1'b1; r_v = 1'b0;
    #1;
    e = ex(0, 0, 0, 0, 1, 1, 1);
    compared++;
    if ((obs & M_IDLE) !== (e & M_IDLE)) begin
      mismatched++;
      $display("FAIL rstmid_enq got=%b want=%b", obs, e);
    end
    @(negedge clk);
    w_v = 1'b0; reset_n = 1'b0;
    #1;
    e = ex(1, 1, 0, 2'b01, 0, 0, 0);
    compared++;
    if (obs !== e) begin
      mismatched++;
      $display("FAIL rstmid_async got=%b want=%b", obs, e);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      e = ex(1, 1, IW'(i), 2'b01, 0, 0, 0);
      compared++;
      if (obs !== e) begin
        mismatched++;
        $display("FAIL rstmid_sweep[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      #1;
      e = ex(0, 0, 0, 0, 1, 1, 1);
      compared++;
      if ((obs & M_IDLE) !== (e & M_IDLE)) begin
        mismatched++;
        $display("FAIL rstmid_no_update[%0d] got=%b want=%b", i, obs, e);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_init();
    test_update();
    test_starve();
    test_full();
    test_clear();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
